// File: rtl/rggen_axi4lite_register_slice_pkg.sv
// rggen_axi4lite_register_slice_pkg: AXI4-Lite response codes shared by the slice, its neighbours and benches
package rggen_axi4lite_register_slice_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage

// File: rtl/rggen_axi4lite_skid_buffer.sv
// rggen_axi4lite_skid_buffer: 2-entry registered valid/ready slice, or a plain wire-through when ENABLE is 0
module rggen_axi4lite_skid_buffer #(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t           state, state_next;
    logic             ready_q;
    logic             s_hs;
    logic [WIDTH-1:0] out_q, skd_q;
    assign s_hs = i_valid && ready_q;
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   state_next = s_hs ? BUSY : EMPTY;
            BUSY:    state_next = (s_hs && !i_ready) ? FULL : (!s_hs && i_ready) ? EMPTY : BUSY;
            FULL:    state_next = i_ready ? BUSY : FULL;
            default: state_next = EMPTY;
        endcase
    end
    // ready is its own register so it stays low for the whole reset and rises one edge after release
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= state_next != FULL;
        end
    end
    always_ff @(posedge i_clk) begin
        if (state == FULL) begin
            if (i_ready) out_q <= skd_q;
        end else if (s_hs) begin
            if (state == EMPTY || i_ready) out_q <= i_data;
            else skd_q <= i_data;
        end
    end
    assign o_valid = ENABLE ? (state != EMPTY) : i_valid;
    assign o_ready = ENABLE ? ready_q : i_ready;
    assign o_data  = ENABLE ? out_q : i_data;
endmodule

// File: rtl/rggen_axi4lite_register_slice.sv
// rggen_axi4lite_register_slice: per-channel registered AXI4-Lite slice in front of rggen_axi4lite_adapter
module rggen_axi4lite_register_slice
    import rggen_axi4lite_register_slice_pkg::*;
#(
    parameter int       ID_WIDTH        = 0,
    parameter int       ADDRESS_WIDTH   = 8,
    parameter int       BUS_WIDTH       = 32,
    parameter logic [4:0] SLICE_ENABLE  = 5'b11111,
    localparam int      ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
    input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
    input  logic [2:0]                 i_awprot,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [BUS_WIDTH-1:0]       i_wdata,
    input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
    input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
    input  logic [2:0]                 i_arprot,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
    output logic [1:0]                 o_rresp,
    output logic [BUS_WIDTH-1:0]       o_rdata,
    output logic                       o_m_awvalid,
    input  logic                       i_m_awready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_m_awid,
    output logic [ADDRESS_WIDTH-1:0]   o_m_awaddr,
    output logic [2:0]                 o_m_awprot,
    output logic                       o_m_wvalid,
    input  logic                       i_m_wready,
    output logic [BUS_WIDTH-1:0]       o_m_wdata,
    output logic [BUS_WIDTH/8-1:0]     o_m_wstrb,
    input  logic                       i_m_bvalid,
    output logic                       o_m_bready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_m_bid,
    input  logic [1:0]                 i_m_bresp,
    output logic                       o_m_arvalid,
    input  logic                       i_m_arready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_m_arid,
    output logic [ADDRESS_WIDTH-1:0]   o_m_araddr,
    output logic [2:0]                 o_m_arprot,
    input  logic                       i_m_rvalid,
    output logic                       o_m_rready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_m_rid,
    input  logic [1:0]                 i_m_rresp,
    input  logic [BUS_WIDTH-1:0]       i_m_rdata
);
    localparam int IW = ACTUAL_ID_WIDTH;
    logic [IW-1:0] awid, arid, bid, rid, awid_d, arid_d, bid_d, rid_d;
    // without IDs the id lanes carry a constant 0 and the id outputs are forced to 0
    assign awid       = (ID_WIDTH > 0) ? i_awid : '0;
    assign arid       = (ID_WIDTH > 0) ? i_arid : '0;
    assign bid        = (ID_WIDTH > 0) ? i_m_bid : '0;
    assign rid        = (ID_WIDTH > 0) ? i_m_rid : '0;
    assign o_m_awid   = (ID_WIDTH > 0) ? awid_d : '0;
    assign o_m_arid   = (ID_WIDTH > 0) ? arid_d : '0;
    assign o_bid      = (ID_WIDTH > 0) ? bid_d : '0;
    assign o_rid      = (ID_WIDTH > 0) ? rid_d : '0;
    rggen_axi4lite_skid_buffer #(.WIDTH(IW + ADDRESS_WIDTH + 3), .ENABLE(SLICE_ENABLE[0])) u_aw (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_awvalid), .o_ready(o_awready), .i_data({awid, i_awaddr, i_awprot}),
        .o_valid(o_m_awvalid), .i_ready(i_m_awready), .o_data({awid_d, o_m_awaddr, o_m_awprot})
    );
    rggen_axi4lite_skid_buffer #(.WIDTH(BUS_WIDTH + BUS_WIDTH / 8), .ENABLE(SLICE_ENABLE[1])) u_w (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_wvalid), .o_ready(o_wready), .i_data({i_wdata, i_wstrb}),
        .o_valid(o_m_wvalid), .i_ready(i_m_wready), .o_data({o_m_wdata, o_m_wstrb})
    );
    rggen_axi4lite_skid_buffer #(.WIDTH(IW + 2), .ENABLE(SLICE_ENABLE[2])) u_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_m_bvalid), .o_ready(o_m_bready), .i_data({bid, i_m_bresp}),
        .o_valid(o_bvalid), .i_ready(i_bready), .o_data({bid_d, o_bresp})
    );
    rggen_axi4lite_skid_buffer #(.WIDTH(IW + ADDRESS_WIDTH + 3), .ENABLE(SLICE_ENABLE[3])) u_ar (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_arvalid), .o_ready(o_arready), .i_data({arid, i_araddr, i_arprot}),
        .o_valid(o_m_arvalid), .i_ready(i_m_arready), .o_data({arid_d, o_m_araddr, o_m_arprot})
    );
    rggen_axi4lite_skid_buffer #(.WIDTH(IW + 2 + BUS_WIDTH), .ENABLE(SLICE_ENABLE[4])) u_r (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_m_rvalid), .o_ready(o_m_rready), .i_data({rid, i_m_rresp, i_m_rdata}),
        .o_valid(o_rvalid), .i_ready(i_rready), .o_data({rid_d, o_rresp, o_rdata})
    );
endmodule

// File: tb/tb_rggen_axi4lite_register_slice.sv
// tb_rggen_axi4lite_register_slice: FIFO-model, table and directed checks of a fully sliced and a B-only sliced instance
module tb_rggen_axi4lite_register_slice;
    import rggen_axi4lite_register_slice_pkg::*;
    localparam int CW [6] = '{15, 36, 6, 15, 38, 3};
    typedef struct {
        logic       v;
        logic [7:0] a;
        logic       rdy;
        logic       ev;
        logic [7:0] ea;
        logic       er;
    } aw_vec_t;
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    logic        i_rst;
    logic [4:0]  sv, dr;
    logic [63:0] sd [5];
    int checks = 0;
    int errors = 0;
    string nm [6] = '{"aw", "w", "b", "ar", "r", "b2"};
    logic [63:0] mq [6][2];
    int          mc [6];
    logic        mr [6];
    logic [31:0] wlog [$];
    logic [31:0] rlog [$];
    logic awready, wready, bvalid, arready, rvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [3:0] bid, rid, m_awid, m_arid, m_wstrb;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata, m_wdata;
    logic [7:0] m_awaddr, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic awready2, wready2, bvalid2, arready2, rvalid2, m_awvalid2, m_wvalid2, m_bready2, m_arvalid2, m_rready2;
    logic bid2, rid2, m_awid2, m_arid2;
    logic [1:0] bresp2, rresp2;
    logic [31:0] rdata2, m_wdata2;
    logic [7:0] m_awaddr2, m_araddr2;
    logic [2:0] m_awprot2, m_arprot2;
    logic [3:0] m_wstrb2;
    logic [5:0]  dv, sr;
    logic [63:0] dd [6];
    assign dv = {bvalid2, rvalid, m_arvalid, bvalid, m_wvalid, m_awvalid};
    assign sr = {m_bready2, m_rready, arready, m_bready, wready, awready};
    assign dd[0] = 64'({m_awid, m_awaddr, m_awprot});
    assign dd[1] = 64'({m_wdata, m_wstrb});
    assign dd[2] = 64'({bid, bresp});
    assign dd[3] = 64'({m_arid, m_araddr, m_arprot});
    assign dd[4] = 64'({rid, rresp, rdata});
    assign dd[5] = 64'({bid2, bresp2});
    rggen_axi4lite_register_slice #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .SLICE_ENABLE(5'b11111)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awvalid(sv[0]), .o_awready(awready), .i_awid(sd[0][14:11]), .i_awaddr(sd[0][10:3]), .i_awprot(sd[0][2:0]),
        .i_wvalid(sv[1]), .o_wready(wready), .i_wdata(sd[1][35:4]), .i_wstrb(sd[1][3:0]),
        .o_bvalid(bvalid), .i_bready(dr[2]), .o_bid(bid), .o_bresp(bresp),
        .i_arvalid(sv[3]), .o_arready(arready), .i_arid(sd[3][14:11]), .i_araddr(sd[3][10:3]), .i_arprot(sd[3][2:0]),
        .o_rvalid(rvalid), .i_rready(dr[4]), .o_rid(rid), .o_rresp(rresp), .o_rdata(rdata),
        .o_m_awvalid(m_awvalid), .i_m_awready(dr[0]), .o_m_awid(m_awid), .o_m_awaddr(m_awaddr), .o_m_awprot(m_awprot),
        .o_m_wvalid(m_wvalid), .i_m_wready(dr[1]), .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb),
        .i_m_bvalid(sv[2]), .o_m_bready(m_bready), .i_m_bid(sd[2][5:2]), .i_m_bresp(sd[2][1:0]),
        .o_m_arvalid(m_arvalid), .i_m_arready(dr[3]), .o_m_arid(m_arid), .o_m_araddr(m_araddr), .o_m_arprot(m_arprot),
        .i_m_rvalid(sv[4]), .o_m_rready(m_rready), .i_m_rid(sd[4][37:34]), .i_m_rresp(sd[4][33:32]), .i_m_rdata(sd[4][31:0])
    );
    rggen_axi4lite_register_slice #(.ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .SLICE_ENABLE(5'b00100)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awvalid(sv[0]), .o_awready(awready2), .i_awid(sd[0][11]), .i_awaddr(sd[0][10:3]), .i_awprot(sd[0][2:0]),
        .i_wvalid(sv[1]), .o_wready(wready2), .i_wdata(sd[1][35:4]), .i_wstrb(sd[1][3:0]),
        .o_bvalid(bvalid2), .i_bready(dr[2]), .o_bid(bid2), .o_bresp(bresp2),
        .i_arvalid(sv[3]), .o_arready(arready2), .i_arid(sd[3][11]), .i_araddr(sd[3][10:3]), .i_arprot(sd[3][2:0]),
        .o_rvalid(rvalid2), .i_rready(dr[4]), .o_rid(rid2), .o_rresp(rresp2), .o_rdata(rdata2),
        .o_m_awvalid(m_awvalid2), .i_m_awready(dr[0]), .o_m_awid(m_awid2), .o_m_awaddr(m_awaddr2), .o_m_awprot(m_awprot2),
        .o_m_wvalid(m_wvalid2), .i_m_wready(dr[1]), .o_m_wdata(m_wdata2), .o_m_wstrb(m_wstrb2),
        .i_m_bvalid(sv[2]), .o_m_bready(m_bready2), .i_m_bid(sd[2][2]), .i_m_bresp(sd[2][1:0]),
        .o_m_arvalid(m_arvalid2), .i_m_arready(dr[3]), .o_m_arid(m_arid2), .o_m_araddr(m_araddr2), .o_m_arprot(m_arprot2),
        .i_m_rvalid(sv[4]), .o_m_rready(m_rready2), .i_m_rid(sd[4][34]), .i_m_rresp(sd[4][33:32]), .i_m_rdata(sd[4][31:0])
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // One clock: bypass checks before the edge, FIFO model update, then compare every sliced channel after it
    task automatic step();
        int          cc;
        logic        v, r;
        logic [63:0] d, mask;
        #1;
        chk("byp_aw", 64'({m_awvalid2, awready2, m_awid2, m_awaddr2, m_awprot2}), 64'({sv[0], dr[0], 1'b0, sd[0][10:0]}));
        chk("byp_w", 64'({m_wvalid2, wready2, m_wdata2, m_wstrb2}), 64'({sv[1], dr[1], sd[1][35:0]}));
        chk("byp_ar", 64'({m_arvalid2, arready2, m_arid2, m_araddr2, m_arprot2}), 64'({sv[3], dr[3], 1'b0, sd[3][10:0]}));
        chk("byp_r", 64'({rvalid2, m_rready2, rid2, rresp2, rdata2}), 64'({sv[4], dr[4], 1'b0, sd[4][33:0]}));
        if (m_wvalid && dr[1]) wlog.push_back(m_wdata);
        if (rvalid && dr[4]) rlog.push_back(rdata);
        for (int c = 0; c < 6; c++) begin
            cc   = (c == 5) ? 2 : c;
            v    = sv[cc];
            r    = dr[cc];
            mask = (64'd1 << CW[c]) - 64'd1;
            d    = (c == 5) ? {62'd0, sd[2][1:0]} : (sd[cc] & mask);
            if (i_rst) begin
                mc[c] = 0;
                mr[c] = 1'b0;
            end else begin
                if (mc[c] > 0 && r) begin
                    mq[c][0] = mq[c][1];
                    mc[c]    = mc[c] - 1;
                end
                if (v && mr[c]) begin
                    mq[c][mc[c]] = d;
                    mc[c]        = mc[c] + 1;
                end
                mr[c] = mc[c] < 2;
            end
        end
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            mask = (64'd1 << CW[c]) - 64'd1;
            chk($sformatf("%s_valid", nm[c]), 64'(dv[c]), 64'(mc[c] > 0));
            chk($sformatf("%s_ready", nm[c]), 64'(sr[c]), 64'(mr[c]));
            if (mc[c] > 0) chk($sformatf("%s_data", nm[c]), dd[c] & mask, mq[c][0]);
        end
    endtask
    initial begin
        aw_vec_t tbl [5];
        tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1};
        tbl[2] = '{1'b1, 8'h14, 1'b1, 1'b1, 8'h14, 1'b1};
        tbl[3] = '{1'b1, 8'h18, 1'b1, 1'b1, 8'h18, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        i_rst = 1'b1;
        sv    = '0;
        dr    = '0;
        for (int i = 0; i < 5; i++) sd[i] = '0;
        for (int i = 0; i < 6; i++) begin
            mc[i] = 0;
            mr[i] = 1'b0;
        end
        step();
        step();
        chk("rst_valid", 64'({m_awvalid, m_wvalid, bvalid, m_arvalid, rvalid, bvalid2}), 64'd0);
        chk("rst_ready", 64'({awready, wready, m_bready, arready, m_rready, m_bready2}), 64'd0);
        i_rst = 1'b0;
        dr    = '1;
        for (int i = 0; i < 5; i++) begin
            sv[0] = tbl[i].v;
            sd[0] = 64'({4'h5, tbl[i].a, 3'b010});
            dr[0] = tbl[i].rdy;
            step();
            chk("tbl_awvalid", 64'(m_awvalid), 64'(tbl[i].ev));
            chk("tbl_awready", 64'(awready), 64'(tbl[i].er));
            if (tbl[i].ev) chk("tbl_awaddr", 64'(m_awaddr), 64'(tbl[i].ea));
        end
        sv = '0;
        dr = '1;
        wlog.delete();
        sv[1] = 1'b1;
        sd[1] = 64'({32'hA0, 4'hF});
        step();
        sd[1] = 64'({32'hA1, 4'hF});
        dr[1] = 1'b0;
        step();
        chk("w_ready_drop", 64'(wready), 64'd0);
        chk("w_hold", 64'(m_wdata), 64'hA0);
        sd[1] = 64'({32'hA2, 4'hF});
        step();
        chk("w_hold", 64'(m_wdata), 64'hA0);
        step();
        chk("w_hold", 64'(m_wdata), 64'hA0);
        dr[1] = 1'b1;
        step();
        chk("w_ready_back", 64'(wready), 64'd1);
        step();
        sd[1] = 64'({32'hA3, 4'hF});
        step();
        sv[1] = 1'b0;
        step();
        step();
        chk("w_count", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < wlog.size(); i++) chk("w_order", 64'(wlog[i]), 64'(32'hA0 + i));
        dr[3] = 1'b0;
        sv[3] = 1'b1;
        sd[3] = 64'({4'h2, 8'h20, 3'b000});
        step();
        sd[3] = 64'({4'h2, 8'h24, 3'b000});
        step();
        chk("ar_full", 64'(arready), 64'd0);
        sv[3] = 1'b0;
        i_rst = 1'b1;
        step();
        chk("ar_rst_valid", 64'(m_arvalid), 64'd0);
        chk("ar_rst_ready", 64'(arready), 64'd0);
        i_rst = 1'b0;
        dr[3] = 1'b1;
        step();
        chk("ar_rel_ready", 64'(arready), 64'd1);
        chk("ar_no_stale", 64'(m_arvalid), 64'd0);
        step();
        chk("ar_no_stale", 64'(m_arvalid), 64'd0);
        dr[4] = 1'b0;
        sv[4] = 1'b1;
        sd[4] = 64'({4'd3, AXI_RESP_SLVERR, 32'hDEADBEEF});
        step();
        sv[4] = 1'b0;
        step();
        step();
        chk("r_valid", 64'(rvalid), 64'd1);
        chk("r_id", 64'(rid), 64'd3);
        chk("r_resp", 64'(rresp), 64'(AXI_RESP_SLVERR));
        chk("r_data", 64'(rdata), 64'hDEADBEEF);
        rlog.delete();
        dr[4] = 1'b1;
        step();
        chk("r_count", 64'(rlog.size()), 64'd1);
        chk("r_delivered", 64'(rlog.size() > 0 ? rlog[0] : 32'd0), 64'hDEADBEEF);
        chk("r_drained", 64'(rvalid), 64'd0);
        for (int n = 0; n < 800; n++) begin
            i_rst = ($urandom_range(0, 63) == 0);
            sv    = 5'($urandom);
            dr    = 5'($urandom);
            for (int i = 0; i < 5; i++) sd[i] = {$urandom, $urandom};
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
